// File: rtl/imem_load_sequencer.sv
// Debug-side UART command decoder: loads big-endian words into instruction memory and
// drives pipeline step enable. Optional macro LOAD_TIMEOUT_EN aborts a stalled load.
module imem_load_sequencer #(
  parameter int          SIZE_ADDR_PC   = 32,
  parameter int          TOTAL_SIZE     = 256,
  parameter logic [7:0]  CMD_LOAD       = 8'h4C,
  parameter logic [7:0]  CMD_STEP       = 8'h53,
  parameter logic [7:0]  CMD_CONT       = 8'h43,
  parameter logic [31:0] HALT_WORD      = 32'hFFFFFFFF,
  parameter int          TIMEOUT_CYCLES = 1024
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic [7:0]              i_rx_data,
  input  logic                    i_rx_done,
  input  logic                    i_halt,
  output logic [SIZE_ADDR_PC-1:0] o_instruction,
  output logic [SIZE_ADDR_PC-1:0] o_instruction_address,
  output logic                    o_flag_write_intruc,
  output logic                    o_step,
  output logic                    o_loaded,
  output logic                    o_overflow,
  output logic                    o_busy,
  output logic [2:0]              o_state
);

  if ((TOTAL_SIZE % 4) != 0 || TOTAL_SIZE < 4) begin : g_bad_size
    $error("TOTAL_SIZE must be a positive multiple of 4");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_WRITE = 3'd2,
    S_STEP  = 3'd3,
    S_RUN   = 3'd4
  } state_t;

  localparam logic [SIZE_ADDR_PC-1:0] LAST_ADDR = SIZE_ADDR_PC'(TOTAL_SIZE - 4);
  localparam logic [SIZE_ADDR_PC-1:0] HALT_W    = SIZE_ADDR_PC'(HALT_WORD);

  state_t                  state_q, state_d;
  logic [SIZE_ADDR_PC-1:0] word_q, word_d;
  logic [SIZE_ADDR_PC-1:0] addr_q, addr_d;
  logic [1:0]              bcnt_q, bcnt_d;
  logic                    loaded_q, loaded_d;
  logic                    ovf_q, ovf_d;
  logic                    wr_q, wr_d;
  logic                    step_q, step_d;
  logic [SIZE_ADDR_PC-1:0] word_shift;

  assign word_shift = {word_q[SIZE_ADDR_PC-9:0], i_rx_data};

`ifdef LOAD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] tcnt_q, tcnt_d;
`endif

  always_comb begin
    state_d  = state_q;
    word_d   = word_q;
    addr_d   = addr_q;
    bcnt_d   = bcnt_q;
    loaded_d = loaded_q;
    ovf_d    = ovf_q;
`ifdef LOAD_TIMEOUT_EN
    tcnt_d   = '0;
`endif
    case (state_q)
      S_IDLE: begin
        if (i_rx_done) begin
          case (i_rx_data)
            CMD_LOAD: begin
              state_d = S_LOAD;
              addr_d  = '0;
              bcnt_d  = '0;
              ovf_d   = 1'b0;
            end
            CMD_STEP: if (loaded_q && !i_halt) state_d = S_STEP;
            CMD_CONT: if (loaded_q && !i_halt) state_d = S_RUN;
            default:  ;
          endcase
        end
      end
      S_LOAD: begin
        if (i_rx_done) begin
          word_d = word_shift;
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) state_d = S_WRITE;
        end
`ifdef LOAD_TIMEOUT_EN
        else if (tcnt_q == T_LAST) begin
          state_d  = S_IDLE;
          loaded_d = 1'b0;
          ovf_d    = 1'b0;
          bcnt_d   = '0;
          word_d   = '0;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
`endif
      end
      S_WRITE: begin
        // A byte arriving in this cycle starts the next word; dropped if the load ends here.
        if (word_q == HALT_W) begin
          loaded_d = 1'b1;
          state_d  = S_IDLE;
        end else if (addr_q == LAST_ADDR) begin
          loaded_d = 1'b1;
          ovf_d    = 1'b1;
          state_d  = S_IDLE;
        end else begin
          addr_d  = addr_q + SIZE_ADDR_PC'(4);
          state_d = S_LOAD;
          bcnt_d  = '0;
          if (i_rx_done) begin
            word_d = word_shift;
            bcnt_d = 2'd1;
          end
        end
      end
      S_STEP:  state_d = S_IDLE;
      S_RUN:   if (i_halt) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    wr_d   = (state_d == S_WRITE);
    step_d = (state_d == S_STEP) || (state_d == S_RUN);
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q  <= S_IDLE;
      word_q   <= '0;
      addr_q   <= '0;
      bcnt_q   <= '0;
      loaded_q <= 1'b0;
      ovf_q    <= 1'b0;
      wr_q     <= 1'b0;
      step_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      word_q   <= word_d;
      addr_q   <= addr_d;
      bcnt_q   <= bcnt_d;
      loaded_q <= loaded_d;
      ovf_q    <= ovf_d;
      wr_q     <= wr_d;
      step_q   <= step_d;
    end
  end

`ifdef LOAD_TIMEOUT_EN
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) tcnt_q <= '0;
    else          tcnt_q <= tcnt_d;
  end
`endif

  assign o_instruction         = word_q;
  assign o_instruction_address = addr_q;
  assign o_flag_write_intruc   = wr_q;
  assign o_step                = step_q;
  assign o_loaded              = loaded_q;
  assign o_overflow            = ovf_q;
  assign o_busy                = (state_q != S_IDLE);
  assign o_state               = state_q;

endmodule

// File: tb/tb_imem_load_sequencer.sv
// Randomized bench for imem_load_sequencer with a queue-based reference model and
// per-cycle output comparison plus directed literal checks.
module tb_imem_load_sequencer;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_done;
  logic        halt;
  logic [31:0] instr, iaddr;
  logic        wr, step, loaded, ovf, busy;
  logic [2:0]  state;

  int checks = 0;
  int errors = 0;

  imem_load_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
    .i_clk(clk), .i_reset(rst_n), .i_rx_data(rx_data), .i_rx_done(rx_done),
    .i_halt(halt), .o_instruction(instr), .o_instruction_address(iaddr),
    .o_flag_write_intruc(wr), .o_step(step), .o_loaded(loaded), .o_overflow(ovf),
    .o_busy(busy), .o_state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: mode numbers follow the documented state encodings.
  int          m_mode;
  logic [7:0]  m_bytes[$];
  logic [31:0] m_word, m_addr;
  bit          m_loaded, m_ovf;
  int          m_tcnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_bytes.delete(); m_word = 0; m_addr = 0;
      m_loaded = 0; m_ovf = 0; m_tcnt = 0;
    end else begin
      case (m_mode)
        0: if (rx_done) begin
          if (rx_data == 8'h4C) begin
            m_mode = 1; m_addr = 0; m_ovf = 0; m_bytes.delete(); m_tcnt = 0;
          end else if ((rx_data == 8'h53 || rx_data == 8'h43) && m_loaded && !halt)
            m_mode = (rx_data == 8'h53) ? 3 : 4;
        end
        1: begin
          if (rx_done) begin
            m_bytes.push_back(rx_data);
            m_tcnt = 0;
            if (m_bytes.size() == 4) begin
              m_word = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
              m_bytes.delete();
              m_mode = 2;
            end
          end
`ifdef LOAD_TIMEOUT_EN
          else if (m_tcnt == TO - 1) begin
            m_mode = 0; m_loaded = 0; m_ovf = 0; m_bytes.delete(); m_tcnt = 0;
          end else m_tcnt++;
`endif
        end
        2: begin
          if (m_word == 32'hFFFFFFFF || m_addr == 32'd252) begin
            m_loaded = 1; m_ovf = (m_word != 32'hFFFFFFFF); m_mode = 0;
          end else begin
            m_addr += 4; m_mode = 1; m_tcnt = 0;
            if (rx_done) m_bytes.push_back(rx_data);
          end
        end
        3: m_mode = 0;
        4: if (halt) m_mode = 0;
        default: m_mode = 0;
      endcase
    end
  end

  // Per-cycle comparison plus write/step observation for directed checks.
  logic [31:0] w_addr[$], w_data[$];
  int step_cnt = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      chk("state", 32'(state), 32'(m_mode));
      chk("write_en", 32'(wr), 32'(m_mode == 2));
      chk("step", 32'(step), 32'(m_mode == 3 || m_mode == 4));
      chk("busy", 32'(busy), 32'(m_mode != 0));
      chk("loaded", 32'(loaded), 32'(m_loaded));
      chk("overflow", 32'(ovf), 32'(m_ovf));
      chk("address", iaddr, m_addr);
      if (m_mode == 2) chk("instruction", instr, m_word);
      if (wr) begin w_addr.push_back(iaddr); w_data.push_back(instr); end
      if (step) step_cnt++;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    rx_data = b; rx_done = 1'b1;
    @(posedge clk); #1;
    rx_done = 1'b0;
    idle(gap);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int i = 3; i >= 0; i--) send(w[i*8 +: 8], gap);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_state"}, 32'(state), 0);
    chk({nm, "_step"}, 32'(step), 0);
    chk({nm, "_wr"}, 32'(wr), 0);
    chk({nm, "_busy"}, 32'(busy), 0);
    chk({nm, "_loaded"}, 32'(loaded), 0);
    chk({nm, "_ovf"}, 32'(ovf), 0);
    chk({nm, "_addr"}, iaddr, 0);
    chk({nm, "_instr"}, instr, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    int n;
    rst_n = 1'b0; rx_done = 1'b0; rx_data = 8'h00; halt = 1'b0;
    #3;
    chk_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);

    // Step before any load is ignored.
    step_cnt = 0;
    send(8'h53, 3);
    chk("step_before_load", step_cnt, 0);

    // Basic two-word load.
    w_addr.delete(); w_data.delete();
    send(8'h4C, 1); send_word(32'h00000001, 1); send_word(32'hFFFFFFFF, 1);
    idle(3);
    chk("load_wcount", w_addr.size(), 2);
    if (w_addr.size() == 2) begin
      chk("load_a0", w_addr[0], 32'h0); chk("load_d0", w_data[0], 32'h00000001);
      chk("load_a1", w_addr[1], 32'h4); chk("load_d1", w_data[1], 32'hFFFFFFFF);
    end
    chk("load_loaded", 32'(loaded), 1);
    chk("load_ovf", 32'(ovf), 0);
    chk("load_state", 32'(state), 0);

    // Single step after load.
    step_cnt = 0;
    send(8'h53, 4);
    chk("step_one_cycle", step_cnt, 1);

    // Continuous run; step byte during run ignored; halt stops next cycle.
    send(8'h43, 0);
    idle(4);
    send(8'h53, 2);
    halt = 1'b1;
    @(negedge clk);
    chk("run_step_held", 32'(step), 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("halt_step_off", 32'(step), 0);
    chk("halt_state", 32'(state), 0);
    @(posedge clk); #1;
    halt = 1'b0;
    idle(2);

    // Back-to-back bytes, including one during the write cycle.
    w_addr.delete(); w_data.delete();
    send(8'h4C, 0);
    send_word(32'h00000002, 0); send_word(32'h11223344, 0); send_word(32'hFFFFFFFF, 0);
    idle(3);
    chk("b2b_wcount", w_addr.size(), 3);
    if (w_addr.size() == 3) begin
      chk("b2b_d1", w_data[1], 32'h11223344);
      chk("b2b_a2", w_addr[2], 32'h8);
    end

    // Overflow: 64 non-halt words fill memory.
    w_addr.delete(); w_data.delete();
    send(8'h4C, 0);
    for (int i = 0; i < 64; i++) send_word(32'h00000001, $urandom_range(0, 1));
    idle(3);
    send(8'h00, 0); send(8'h01, 2);
    chk("ovf_wcount", w_addr.size(), 64);
    if (w_addr.size() == 64) chk("ovf_last_addr", w_addr[63], 32'd252);
    chk("ovf_flag", 32'(ovf), 1);
    chk("ovf_loaded", 32'(loaded), 1);
    chk("ovf_state", 32'(state), 0);

`ifdef LOAD_TIMEOUT_EN
    n = w_addr.size();
    send(8'h4C, 0); send(8'hAA, 0); send(8'hBB, 0);
    idle(TO + 4);
    chk("timeout_state", 32'(state), 0);
    chk("timeout_loaded", 32'(loaded), 0);
    chk("timeout_nowrite", w_addr.size(), n);
`endif

    // Randomized traffic against the model.
    for (int it = 0; it < 300; it++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: begin
          send(8'h4C, $urandom_range(0, 2));
          n = $urandom_range(1, 6);
          for (int k = 0; k < n; k++)
            send_word(($urandom_range(0, 2) == 0 || k == n - 1) ? 32'hFFFFFFFF : $urandom,
                      $urandom_range(0, 2));
        end
        3, 4: begin
          halt = ($urandom_range(0, 3) == 0);
          send(8'h53, $urandom_range(0, 2));
          halt = 1'b0;
        end
        5, 6: begin
          halt = ($urandom_range(0, 3) == 0);
          send(8'h43, 0);
          halt = 1'b0;
          n = $urandom_range(1, 12);
          for (int k = 0; k < n; k++) begin
            b = 8'($urandom);
            if ($urandom_range(0, 1) == 1) send(b, 0); else idle(1);
          end
          halt = 1'b1;
          rx_data = 8'h53; rx_done = ($urandom_range(0, 1) == 1);
          idle(1);
          rx_done = 1'b0;
          idle($urandom_range(0, 2));
          halt = 1'b0;
        end
        default: begin
          b = 8'($urandom);
          send(b, $urandom_range(0, 3));
        end
      endcase
    end
    idle(4);

    // Asynchronous reset in the middle of a run.
    rst_n = 1'b0; idle(1); rst_n = 1'b1; idle(1);
    send(8'h4C, 0); send_word(32'h00000007, 0); send_word(32'hFFFFFFFF, 0);
    idle(2);
    send(8'h43, 0);
    idle(3);
    #2;
    chk("run_before_reset", 32'(step), 1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/imem_load_sequencer.md
Name: imem_load_sequencer

Overview:
- Debug-side controller for the instruction memory and pipeline step control.
- Takes a UART byte stream and decodes one-byte commands.
- Loads a program by assembling big-endian 32-bit words and issuing single-cycle writes (address, data, write flag) into the instruction memory.
- Sequences execution by driving the pipeline step enable in single-step or continuous mode until the pipeline reports halt.

Parameters:
- SIZE_ADDR_PC, 32, width of instruction word and byte address
- TOTAL_SIZE, 256, instruction memory size in bytes; must be a multiple of 4
- CMD_LOAD, 8'h4C, command byte 'L': start program load
- CMD_STEP, 8'h53, command byte 'S': one pipeline step
- CMD_CONT, 8'h43, command byte 'C': run continuously until halt
- HALT_WORD, 32'hFFFFFFFF, instruction word that terminates a load
- TIMEOUT_CYCLES, 1024, load inactivity limit (used only with the optional feature)

Ports:
- i_clk, input, 1, system clock; all logic is on the rising edge
- i_reset, input, 1, asynchronous active-low reset
- i_rx_data, input, 8, received UART byte
- i_rx_done, input, 1, one-cycle strobe; i_rx_data is valid in this cycle
- i_halt, input, 1, pipeline has retired the halt instruction (level)
- o_instruction, output, SIZE_ADDR_PC, word to write into instruction memory
- o_instruction_address, output, SIZE_ADDR_PC, byte address for the write
- o_flag_write_intruc, output, 1, instruction memory write enable (one-cycle pulse)
- o_step, output, 1, pipeline advance enable
- o_loaded, output, 1, a program has been loaded since reset
- o_overflow, output, 1, last load filled memory without seeing HALT_WORD
- o_busy, output, 1, high in any state other than IDLE
- o_state, output, 3, current state encoding for debug

Behaviour:
- Reset (i_reset=0, asynchronous):
  - State goes to IDLE.
  - All outputs go to 0, including o_instruction, o_instruction_address, o_loaded and o_overflow.
  - The byte counter clears.
  - Reset asserted mid-load or mid-run aborts immediately. No partial write is issued.
- State encodings: IDLE=0, LOAD=1, WRITE=2, STEP=3, RUN=4.
- IDLE, on i_rx_done:
  - CMD_LOAD: go to LOAD, clear o_instruction_address to 0, byte_cnt=0, o_overflow=0.
  - CMD_STEP: go to STEP, only if o_loaded=1 and i_halt=0. Otherwise the byte is ignored.
  - CMD_CONT: go to RUN under the same condition.
  - Any other byte: ignored.
- LOAD:
  - Each i_rx_done shifts the byte in MSB-first: word = {word[23:0], byte}. byte_cnt increments.
  - On the 4th byte, go to WRITE.
- WRITE (exactly one cycle):
  - o_flag_write_intruc=1, with o_instruction and o_instruction_address stable for the whole cycle.
  - Latency: the 4th byte strobe at cycle N gives the write pulse in cycle N+1.
  - Next cycle, if the word was HALT_WORD: o_loaded=1, go to IDLE.
  - Else, if o_instruction_address==TOTAL_SIZE-4: o_loaded=1, o_overflow=1, go to IDLE.
  - Else: o_instruction_address += 4, byte_cnt=0, go to LOAD.
  - An i_rx_done arriving during WRITE is accepted as byte 0 of the next word. It must not be lost.
- STEP:
  - o_step=1 for exactly one cycle, then go to IDLE.
- RUN:
  - o_step is held at 1.
  - When i_halt=1 is sampled: o_step=0 in the next cycle, go to IDLE.
  - All bytes received in RUN are ignored. If i_halt and i_rx_done coincide, halt wins and the byte is dropped.
- o_step is 0 in every state other than STEP and RUN.
- o_flag_write_intruc is 0 in every state other than WRITE.
- Addresses never wrap. A load always stops at the last word.

Optional Feature:
- Macro: LOAD_TIMEOUT_EN.
- With the macro defined:
  - A counter increments each cycle in LOAD and clears on every i_rx_done.
  - When the counter reaches TIMEOUT_CYCLES-1 with no byte received, the load aborts to IDLE.
  - The abort issues no write, sets o_loaded=0 and o_overflow=0, and discards partial bytes.
- Without the macro: LOAD waits indefinitely and no counter is synthesised.

Test Plan:
- Reset with i_reset=0 mid-RUN -> o_step=0, o_state=0 and all outputs 0 immediately, before the next clock edge.
- Load: bytes 4C, 00, 00, 00, 01, FF, FF, FF, FF -> two write pulses: addr 0 with data 32'h00000001, then addr 4 with data 32'hFFFFFFFF. Afterwards o_loaded=1, o_overflow=0, state IDLE.
- Overflow: 4C followed by 64 words of 32'h00000001 (TOTAL_SIZE=256) -> last write at addr 252, o_overflow=1, no 65th write. Further bytes are ignored as non-commands.
- Step: after a load, byte 53 -> o_step high for exactly 1 cycle. Byte 53 before any load -> o_step remains 0.
- Continuous: byte 43 -> o_step held high. Assert i_halt at cycle K -> o_step=0 at K+1. A byte 53 sent during RUN has no effect.
- Back-to-back: a 4th byte followed by a strobe in the WRITE cycle -> that byte becomes the MSB of the next word. With LOAD_TIMEOUT_EN and TIMEOUT_CYCLES=16, sending 4C then 2 bytes and idling -> return to IDLE after 16 cycles, no write, o_loaded=0.
